// File: rtl/decode_writeback.sv
// rtl/decode_writeback.sv - Y86-64 decode, 15-entry register file and D/E register; DECODE_WB_BYPASS_EN enables write-through reads
module decode_writeback #(
  parameter int         DATA_W = 64,
  parameter logic [3:0] RSP_ID = 4'd4,
  parameter logic [3:0] RNONE  = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [3:0]        d_icode,
  input  logic [3:0]        d_ifun,
  input  logic [3:0]        d_rA,
  input  logic [3:0]        d_rB,
  input  logic [DATA_W-1:0] d_valC,
  input  logic [DATA_W-1:0] d_valP,
  input  logic              stall,
  input  logic              bubble,
  input  logic [3:0]        w_dstE,
  input  logic [DATA_W-1:0] w_valE,
  input  logic [3:0]        w_dstM,
  input  logic [DATA_W-1:0] w_valM,
  output logic              e_valid,
  output logic [3:0]        e_icode,
  output logic [3:0]        e_ifun,
  output logic [DATA_W-1:0] e_valC,
  output logic [DATA_W-1:0] e_valA,
  output logic [DATA_W-1:0] e_valB,
  output logic [3:0]        e_srcA,
  output logic [3:0]        e_srcB,
  output logic [3:0]        e_dstE,
  output logic [3:0]        e_dstM
);

  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  logic [DATA_W-1:0] rf [0:14];
  logic [3:0]        src_a, src_b, dst_e, dst_m;
  logic [DATA_W-1:0] rd_a, rd_b, val_a;

  // Register selects per instruction class; halt, nop, jxx and undefined codes select nothing
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (d_icode)
      I_CMOV:  begin src_a = d_rA;   dst_e = d_rB; end
      I_IRMOV: begin dst_e = d_rB; end
      I_RMMOV: begin src_a = d_rA;   src_b = d_rB; end
      I_MRMOV: begin src_b = d_rB;   dst_m = d_rA; end
      I_OPQ:   begin src_a = d_rA;   src_b = d_rB;   dst_e = d_rB; end
      I_CALL:  begin src_b = RSP_ID; dst_e = RSP_ID; end
      I_RET:   begin src_a = RSP_ID; src_b = RSP_ID; dst_e = RSP_ID; end
      I_PUSH:  begin src_a = d_rA;   src_b = RSP_ID; dst_e = RSP_ID; end
      I_POP:   begin src_a = RSP_ID; src_b = RSP_ID; dst_e = RSP_ID; dst_m = d_rA; end
      default: ;
    endcase
  end

  // Register file reads; RNONE reads as zero, optional write-through with M over E
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (src_a != RNONE) rd_a = rf[src_a];
    if (src_b != RNONE) rd_b = rf[src_b];
`ifdef DECODE_WB_BYPASS_EN
    if (src_a != RNONE) begin
      if (w_dstM == src_a)      rd_a = w_valM;
      else if (w_dstE == src_a) rd_a = w_valE;
    end
    if (src_b != RNONE) begin
      if (w_dstM == src_b)      rd_b = w_valM;
      else if (w_dstE == src_b) rd_b = w_valE;
    end
`endif
    val_a = (d_icode == I_JXX || d_icode == I_CALL) ? d_valP : rd_a;
  end

  // Write-back: both ports on the same edge, M written last so it wins a shared destination
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) rf[i] <= '0;
    end else begin
      if (w_dstE != RNONE) rf[w_dstE] <= w_valE;
      if (w_dstM != RNONE) rf[w_dstM] <= w_valM;
    end
  end

  // D/E pipeline register: reset, then bubble, then stall hold, then load (invalid input loads a NOP)
  always_ff @(posedge clk) begin
    if (reset || bubble || (!stall && !d_valid)) begin
      e_valid <= 1'b0;
      e_icode <= I_NOP;
      e_ifun  <= 4'h0;
      e_valC  <= '0;
      e_valA  <= '0;
      e_valB  <= '0;
      e_srcA  <= RNONE;
      e_srcB  <= RNONE;
      e_dstE  <= RNONE;
      e_dstM  <= RNONE;
    end else if (!stall) begin
      e_valid <= 1'b1;
      e_icode <= d_icode;
      e_ifun  <= d_ifun;
      e_valC  <= d_valC;
      e_valA  <= val_a;
      e_valB  <= rd_b;
      e_srcA  <= src_a;
      e_srcB  <= src_b;
      e_dstE  <= dst_e;
      e_dstM  <= dst_m;
    end
  end

endmodule

// File: tb/tb_decode_writeback.sv
// tb/tb_decode_writeback.sv - self-checking bench for decode_writeback against a behavioural model
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        reset, d_valid, stall, bubble;
  logic [3:0]  d_icode, d_ifun, d_rA, d_rB, w_dstE, w_dstM;
  logic [63:0] d_valC, d_valP, w_valE, w_valM;
  logic        e_valid;
  logic [3:0]  e_icode, e_ifun, e_srcA, e_srcB, e_dstE, e_dstM;
  logic [63:0] e_valC, e_valA, e_valB;

  int checks = 0;
  int errors = 0;

  logic [63:0] mreg [15];
  logic        x_valid;
  logic [3:0]  x_icode, x_ifun, x_srcA, x_srcB, x_dstE, x_dstM;
  logic [63:0] x_valC, x_valA, x_valB;

  decode_writeback dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_rA(d_rA), .d_rB(d_rB), .d_valC(d_valC), .d_valP(d_valP), .stall(stall), .bubble(bubble),
    .w_dstE(w_dstE), .w_valE(w_valE), .w_dstM(w_dstM), .w_valM(w_valM),
    .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun), .e_valC(e_valC), .e_valA(e_valA),
    .e_valB(e_valB), .e_srcA(e_srcA), .e_srcB(e_srcB), .e_dstE(e_dstE), .e_dstM(e_dstM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
    return (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] idx);
    if (idx == 4'hF) return 64'd0;
`ifdef DECODE_WB_BYPASS_EN
    if (w_dstM == idx) return w_valM;
    if (w_dstE == idx) return w_valE;
`endif
    return mreg[idx];
  endfunction

  task automatic exp_bubble();
    x_valid = 1'b0; x_icode = 4'h1; x_ifun = 4'h0;
    x_valC = 64'd0; x_valA = 64'd0; x_valB = 64'd0;
    x_srcA = 4'hF; x_srcB = 4'hF; x_dstE = 4'hF; x_dstM = 4'hF;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(e_valid), 64'(x_valid));
    chk({tag, ".icode"}, 64'(e_icode), 64'(x_icode));
    chk({tag, ".ifun"},  64'(e_ifun),  64'(x_ifun));
    chk({tag, ".valC"},  e_valC, x_valC);
    chk({tag, ".valA"},  e_valA, x_valA);
    chk({tag, ".valB"},  e_valB, x_valB);
    chk({tag, ".srcA"},  64'(e_srcA), 64'(x_srcA));
    chk({tag, ".srcB"},  64'(e_srcB), 64'(x_srcB));
    chk({tag, ".dstE"},  64'(e_dstE), 64'(x_dstE));
    chk({tag, ".dstM"},  64'(e_dstM), 64'(x_dstM));
  endtask

  // Predict from pre-edge state, clock once, then compare every output
  task automatic step(input string tag);
    if (reset) begin
      exp_bubble();
      for (int i = 0; i < 15; i++) mreg[i] = 64'd0;
    end else begin
      if (bubble || (!stall && !d_valid)) exp_bubble();
      else if (!stall) begin
        x_valid = 1'b1; x_icode = d_icode; x_ifun = d_ifun; x_valC = d_valC;
        x_srcA = m_src_a(d_icode, d_rA); x_srcB = m_src_b(d_icode, d_rB);
        x_dstE = m_dst_e(d_icode, d_rB); x_dstM = m_dst_m(d_icode, d_rA);
        x_valA = (d_icode inside {4'h7, 4'h8}) ? d_valP : m_read(x_srcA);
        x_valB = m_read(x_srcB);
      end
      if (w_dstE != 4'hF) mreg[w_dstE] = w_valE;
      if (w_dstM != 4'hF) mreg[w_dstM] = w_valM;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    reset = 0; d_valid = 0; stall = 0; bubble = 0;
    d_icode = 4'h1; d_ifun = 0; d_rA = 4'hF; d_rB = 4'hF; d_valC = 0; d_valP = 0;
    w_dstE = 4'hF; w_valE = 0; w_dstM = 4'hF; w_valM = 0;
  endtask

  task automatic decode(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vp);
    d_valid = 1; d_icode = ic; d_ifun = 0; d_rA = ra; d_rB = rb; d_valC = 64'h0C; d_valP = vp;
  endtask

  initial begin
    exp_bubble();
    for (int i = 0; i < 15; i++) mreg[i] = 64'd0;
    idle();
    @(negedge clk);

    reset = 1; step("reset");
    chk("reset_valid", 64'(e_valid), 64'd0);
    chk("reset_icode", 64'(e_icode), 64'd1);
    chk("reset_srcA", 64'(e_srcA), 64'hF);

    idle(); decode(4'h6, 4'd2, 4'd3, 64'h10); step("opq_after_reset");
    chk("first_valA", e_valA, 64'd0);
    chk("first_dstE", 64'(e_dstE), 64'd3);
    chk("first_valid", 64'(e_valid), 64'd1);

    idle(); w_dstE = 4'd2; w_valE = 64'h1111; step("wr_e");
    idle(); decode(4'h6, 4'd2, 4'd2, 64'h12); step("rd_r2");
    chk("portE_valA", e_valA, 64'h1111);
    chk("portE_valB", e_valB, 64'h1111);
    chk("portE_srcB", 64'(e_srcB), 64'd2);

    idle(); w_dstE = 4'hF; w_valE = 64'h5555; step("wr_rnone");
    idle(); decode(4'h6, 4'd2, 4'd3, 64'h14); step("rd_after_rnone");
    chk("rnone_valA", e_valA, 64'h1111);
    chk("rnone_valB", e_valB, 64'd0);

    idle(); w_dstE = 4'd4; w_valE = 64'hAAAA; w_dstM = 4'd4; w_valM = 64'hBBBB; step("conflict");
    idle(); decode(4'h9, 4'hF, 4'hF, 64'h16); step("ret");
    chk("conflict_valA", e_valA, 64'hBBBB);
    chk("conflict_valB", e_valB, 64'hBBBB);
    chk("conflict_srcA", 64'(e_srcA), 64'd4);

    idle(); w_dstE = 4'd4; w_valE = 64'h100; step("set_rsp");
    idle(); decode(4'h8, 4'hF, 4'hF, 64'h40); step("call");
    chk("call_valA", e_valA, 64'h40);
    chk("call_valB", e_valB, 64'h100);
    chk("call_dstE", 64'(e_dstE), 64'd4);
    chk("call_dstM", 64'(e_dstM), 64'hF);
    idle(); decode(4'hB, 4'd5, 4'hF, 64'h48); step("popq");
    chk("popq_dstM", 64'(e_dstM), 64'd5);
    chk("popq_srcA", 64'(e_srcA), 64'd4);

    idle(); decode(4'h6, 4'd2, 4'd4, 64'h50); step("pre_stall");
    for (int i = 0; i < 3; i++) begin
      decode(4'($urandom_range(0, 11)), 4'($urandom_range(0, 14)), 4'($urandom_range(0, 14)), 64'(i));
      stall = 1; w_dstE = 4'd2; w_valE = 64'h2000 + 64'(i);
      step("stall");
      chk("stall_icode", 64'(e_icode), 64'd6);
      chk("stall_valA", e_valA, 64'h1111);
    end
    idle(); decode(4'h6, 4'd2, 4'd2, 64'h54); step("after_stall");
    chk("stall_wb_valA", e_valA, 64'h2002);

    idle(); decode(4'h6, 4'd2, 4'd2, 64'h58); stall = 1; bubble = 1; step("stall_bubble");
    chk("sb_icode", 64'(e_icode), 64'd1);
    chk("sb_valid", 64'(e_valid), 64'd0);

    idle(); decode(4'h6, 4'd2, 4'd2, 64'h5C); step("load");
    idle(); step("dvalid0");
    chk("dv0_valid", 64'(e_valid), 64'd0);

    idle(); w_dstE = 4'd3; w_valE = 64'h33; step("set_r3");
    idle(); decode(4'h4, 4'd3, 4'd2, 64'h60); w_dstM = 4'd3; w_valM = 64'h77; step("bypass");
`ifdef DECODE_WB_BYPASS_EN
    chk("bypass_valA", e_valA, 64'h77);
`else
    chk("bypass_valA", e_valA, 64'h33);
`endif

    idle(); decode(4'h6, 4'd2, 4'd3, 64'h64); step("pre_rst_stall");
    idle(); stall = 1; reset = 1; step("reset_in_stall");
    chk("rst_stall_icode", 64'(e_icode), 64'd1);
    idle(); decode(4'h6, 4'd2, 4'd3, 64'h68); step("after_reset");
    chk("rst_clear_valA", e_valA, 64'd0);

    for (int n = 0; n < 400; n++) begin
      idle();
      reset   = ($urandom_range(0, 59) == 0);
      d_valid = ($urandom_range(0, 5) != 0);
      stall   = ($urandom_range(0, 4) == 0);
      bubble  = ($urandom_range(0, 9) == 0);
      d_icode = 4'($urandom_range(0, 15));
      d_ifun  = 4'($urandom_range(0, 15));
      d_rA    = 4'($urandom_range(0, 15));
      d_rB    = 4'($urandom_range(0, 15));
      d_valC  = {$urandom, $urandom};
      d_valP  = {$urandom, $urandom};
      w_dstE  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      w_dstM  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      w_valE  = {$urandom, $urandom};
      w_valM  = {$urandom, $urandom};
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
